// File: rtl/lc3_pkg.sv
// Shared LC-3 pipeline definitions: instruction width and opcode encoding.
package lc3_pkg;

  localparam int unsigned IW = 16;

  // Every 4-bit code is named so a cast from IR[15:12] is always a legal value;
  // JSR/RTI/RSV/TRAP are not executed by this pipeline and behave as NOP.
  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RSV  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } op_e;

endpackage

// File: rtl/lc3_alu.sv
// Combinational LC-3 ALU for ADD/AND/NOT; other opcodes yield zero.
module lc3_alu
  import lc3_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] operand2,
  input  op_e           op,
  output logic [DW-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = A + operand2;
      OP_AND:  result = A & operand2;
      OP_NOT:  result = ~A;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// LC-3 execute stage: operand forwarding, ALU/address generation, one-cycle
// registered results with hold-on-stall that suppresses repeated side effects.
module execute
  import lc3_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_execute,
  input  logic [IW-1:0] IR,
  input  logic [DW-1:0] npc_in,
  input  logic [DW-1:0] VSR1,
  input  logic [DW-1:0] VSR2,
  input  logic [DW-1:0] Mem_Bypass_Val,
  input  logic          bypass_alu_1,
  input  logic          bypass_alu_2,
  input  logic          bypass_mem_1,
  input  logic          bypass_mem_2,
  output logic [2:0]    sr1,
  output logic [2:0]    sr2,
  output logic [DW-1:0] aluout,
  output logic [DW-1:0] pcout,
  output logic [DW-1:0] M_Data,
  output logic [2:0]    dr,
  output logic          W_en,
  output logic [2:0]    NZP,
  output logic [IW-1:0] IR_Exec
);

  logic [DW-1:0] aluout_q, aluout_d;
  logic [DW-1:0] pcout_q, pcout_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [2:0]    dr_q, dr_d;
  logic          w_en_q, w_en_d;
  logic [2:0]    nzp_q, nzp_d;
  logic [IW-1:0] ir_exec_q, ir_exec_d;

  op_e           op;
  logic          is_store;
  logic [DW-1:0] a_val, b_val, operand2, alu_res;
  logic [DW-1:0] imm5, off6, off9, pc_rel;

  assign op       = op_e'(IR[15:12]);
  assign is_store = (op == OP_ST) || (op == OP_STR) || (op == OP_STI);

  assign sr1 = IR[8:6];
  assign sr2 = is_store ? IR[11:9] : IR[2:0];

  assign imm5 = {{(DW-5){IR[4]}}, IR[4:0]};
  assign off6 = {{(DW-6){IR[5]}}, IR[5:0]};
  assign off9 = {{(DW-9){IR[8]}}, IR[8:0]};

  // Forwarding reads the currently registered result, so ALU beats memory.
  assign a_val = bypass_alu_1 ? aluout_q : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
  assign b_val = bypass_alu_2 ? aluout_q : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);

  assign operand2 = IR[5] ? imm5 : b_val;
  assign pc_rel   = npc_in + off9;

  lc3_alu #(.DW(DW)) u_alu (
    .A        (a_val),
    .operand2 (operand2),
    .op       (op),
    .result   (alu_res)
  );

  always_comb begin
    aluout_d  = aluout_q;
    pcout_d   = pcout_q;
    m_data_d  = m_data_q;
    dr_d      = dr_q;
    ir_exec_d = ir_exec_q;
    w_en_d    = 1'b0;
    nzp_d     = 3'b000;
    if (enable_execute) begin
      aluout_d  = '0;
      pcout_d   = '0;
      m_data_d  = '0;
      dr_d      = 3'b000;
      ir_exec_d = IR;
      unique case (op)
        OP_ADD, OP_AND, OP_NOT: begin
          aluout_d = alu_res;
          dr_d     = IR[11:9];
          w_en_d   = 1'b1;
        end
        OP_LEA: begin
          aluout_d = pc_rel;
          pcout_d  = pc_rel;
          dr_d     = IR[11:9];
          w_en_d   = 1'b1;
        end
        OP_LD, OP_LDI: begin
          pcout_d = pc_rel;
          dr_d    = IR[11:9];
          w_en_d  = 1'b1;
        end
        OP_LDR: begin
          pcout_d = a_val + off6;
          dr_d    = IR[11:9];
          w_en_d  = 1'b1;
        end
        OP_ST, OP_STI: begin
          pcout_d  = pc_rel;
          m_data_d = b_val;
        end
        OP_STR: begin
          pcout_d  = a_val + off6;
          m_data_d = b_val;
        end
        OP_BR: begin
          pcout_d = pc_rel;
          nzp_d   = IR[11:9];
        end
        OP_JMP: begin
          pcout_d = a_val;
          nzp_d   = 3'b111;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aluout_q  <= '0;
      pcout_q   <= '0;
      m_data_q  <= '0;
      dr_q      <= 3'b000;
      w_en_q    <= 1'b0;
      nzp_q     <= 3'b000;
      ir_exec_q <= '0;
    end else begin
      aluout_q  <= aluout_d;
      pcout_q   <= pcout_d;
      m_data_q  <= m_data_d;
      dr_q      <= dr_d;
      w_en_q    <= w_en_d;
      nzp_q     <= nzp_d;
      ir_exec_q <= ir_exec_d;
    end
  end

  assign aluout  = aluout_q;
  assign pcout   = pcout_q;
  assign M_Data  = m_data_q;
  assign dr      = dr_q;
  assign W_en    = w_en_q;
  assign NZP     = nzp_q;
  assign IR_Exec = ir_exec_q;

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the LC-3 execute stage.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_execute = 1'b0;
  logic [15:0] IR = '0, npc_in = '0, VSR1 = '0, VSR2 = '0, Mem_Bypass_Val = '0;
  logic        bypass_alu_1 = 1'b0, bypass_alu_2 = 1'b0;
  logic        bypass_mem_1 = 1'b0, bypass_mem_2 = 1'b0;
  logic [2:0]  sr1, sr2, dr, NZP;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic        W_en;

  int vectors = 0;
  int miscompares = 0;

  execute #(.DW(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_execute (enable_execute),
    .IR             (IR),
    .npc_in         (npc_in),
    .VSR1           (VSR1),
    .VSR2           (VSR2),
    .Mem_Bypass_Val (Mem_Bypass_Val),
    .bypass_alu_1   (bypass_alu_1),
    .bypass_alu_2   (bypass_alu_2),
    .bypass_mem_1   (bypass_mem_1),
    .bypass_mem_2   (bypass_mem_2),
    .sr1            (sr1),
    .sr2            (sr2),
    .aluout         (aluout),
    .pcout          (pcout),
    .M_Data         (M_Data),
    .dr             (dr),
    .W_en           (W_en),
    .NZP            (NZP),
    .IR_Exec        (IR_Exec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_alu, input logic [15:0] e_pc,
                         input logic [15:0] e_md, input logic [2:0] e_dr, input logic e_wen,
                         input logic [2:0] e_nzp, input logic [15:0] e_ir);
    chk({tag, ".aluout"},  aluout,  e_alu);
    chk({tag, ".pcout"},   pcout,   e_pc);
    chk({tag, ".M_Data"},  M_Data,  e_md);
    chk({tag, ".dr"},      16'(dr), 16'(e_dr));
    chk({tag, ".W_en"},    16'(W_en), 16'(e_wen));
    chk({tag, ".NZP"},     16'(NZP), 16'(e_nzp));
    chk({tag, ".IR_Exec"}, IR_Exec, e_ir);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ir, input logic [15:0] npc,
                       input logic [15:0] v1, input logic [15:0] v2);
    IR = ir; npc_in = npc; VSR1 = v1; VSR2 = v2;
    Mem_Bypass_Val = '0;
    bypass_alu_1 = 1'b0; bypass_alu_2 = 1'b0;
    bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b0;
    enable_execute = 1'b1;
  endtask

  initial begin
    // Reset with random inputs for two edges
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      IR = 16'($urandom); npc_in = 16'($urandom);
      VSR1 = 16'($urandom); VSR2 = 16'($urandom); Mem_Bypass_Val = 16'($urandom);
      enable_execute = 1'($urandom); bypass_alu_1 = 1'($urandom);
      bypass_mem_2 = 1'($urandom);
      step();
    end
    chk_all("reset", 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 3'd0, 16'h0);
    rst = 1'b0;

    // ADD R1, R1, #1 with wrap
    issue(16'h1261, 16'h3000, 16'hFFFF, 16'h0);
    #1 chk("add_imm.sr1", 16'(sr1), 16'd1);
    step();
    chk_all("add_imm", 16'h0000, 16'h0, 16'h0, 3'd1, 1'b1, 3'd0, 16'h1261);

    // Establish aluout = 5
    issue(16'h1261, 16'h3000, 16'h0004, 16'h0);
    step();
    chk("add_five.aluout", aluout, 16'h0005);

    // AND R0, R1, R2 with A from ALU bypass, B from memory bypass
    issue(16'h5042, 16'h3000, 16'hFFFF, 16'h0004);
    bypass_alu_1 = 1'b1; bypass_mem_2 = 1'b1; Mem_Bypass_Val = 16'h0007;
    #1 chk("and_fwd.sr2", 16'(sr2), 16'd2);
    step();
    chk_all("and_fwd", 16'h0005, 16'h0, 16'h0, 3'd0, 1'b1, 3'd0, 16'h5042);

    // ADD R0, R1, R2: A from memory, B with both selects high -> ALU wins
    issue(16'h1042, 16'h3000, 16'h1111, 16'h2222);
    bypass_mem_1 = 1'b1; Mem_Bypass_Val = 16'h0100;
    bypass_alu_2 = 1'b1; bypass_mem_2 = 1'b1;
    step();
    chk("add_prio.aluout", aluout, 16'h0105);

    // Back-to-back dependent ADD R1, R1, #1
    issue(16'h1261, 16'h3000, 16'h9999, 16'h0);
    bypass_alu_1 = 1'b1;
    step();
    chk("add_b2b.aluout", aluout, 16'h0106);

    // NOT R1, R1
    issue(16'h927F, 16'h3000, 16'h00F0, 16'h0);
    step();
    chk_all("not", 16'hFF0F, 16'h0, 16'h0, 3'd1, 1'b1, 3'd0, 16'h927F);

    // AND R2, R3, #-4
    issue(16'h54FC, 16'h3000, 16'h1237, 16'h0);
    step();
    chk_all("and_imm", 16'h1234, 16'h0, 16'h0, 3'd2, 1'b1, 3'd0, 16'h54FC);

    // LEA R3, #-1
    issue(16'hE7FF, 16'h4000, 16'h0, 16'h0);
    step();
    chk_all("lea", 16'h3FFF, 16'h3FFF, 16'h0, 3'd3, 1'b1, 3'd0, 16'hE7FF);

    // STR R5, R1, #1
    issue(16'h7A41, 16'h3000, 16'h3000, 16'hBEEF);
    #1 chk("str.sr2", 16'(sr2), 16'd5);
    chk("str.sr1", 16'(sr1), 16'd1);
    step();
    chk_all("str", 16'h0, 16'h3001, 16'hBEEF, 3'd0, 1'b0, 3'd0, 16'h7A41);

    // LDR R1, R2, #-1
    issue(16'h62BF, 16'h3000, 16'h1000, 16'h0);
    step();
    chk_all("ldr", 16'h0, 16'h0FFF, 16'h0, 3'd1, 1'b1, 3'd0, 16'h62BF);

    // BRnz #-2, then one stalled edge
    issue(16'h0BFE, 16'h3010, 16'h0, 16'h0);
    step();
    chk_all("br", 16'h0, 16'h300E, 16'h0, 3'd0, 1'b0, 3'd5, 16'h0BFE);
    issue(16'h1261, 16'h5555, 16'h1, 16'h1);
    enable_execute = 1'b0;
    step();
    chk_all("br_stall", 16'h0, 16'h300E, 16'h0, 3'd0, 1'b0, 3'd0, 16'h0BFE);

    // JMP R2
    issue(16'hC080, 16'h3000, 16'h2345, 16'h0);
    step();
    chk_all("jmp", 16'h0, 16'h2345, 16'h0, 3'd0, 1'b0, 3'd7, 16'hC080);

    // LD R4, #2, then stall: dr held, W_en cleared
    issue(16'h2802, 16'h5000, 16'h0, 16'h0);
    step();
    chk_all("ld", 16'h0, 16'h5002, 16'h0, 3'd4, 1'b1, 3'd0, 16'h2802);
    enable_execute = 1'b0;
    step();
    chk_all("ld_stall", 16'h0, 16'h5002, 16'h0, 3'd4, 1'b0, 3'd0, 16'h2802);

    // Unassigned opcode behaves as NOP
    issue(16'hD123, 16'h3000, 16'hAAAA, 16'h5555);
    step();
    chk_all("nop", 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 3'd0, 16'hD123);

    // Reset wins over enable; next enabled edge captures fresh inputs
    issue(16'h1261, 16'h3000, 16'h0005, 16'h0);
    rst = 1'b1;
    step();
    chk_all("rst_prio", 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 3'd0, 16'h0);
    rst = 1'b0;
    step();
    chk_all("post_rst", 16'h0006, 16'h0, 16'h0, 3'd1, 1'b1, 3'd0, 16'h1261);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
